bcd_score_keeper: RTL and testbench

Parametrised successor of the game score counter.
- Keeps the running score and the session high score directly in packed BCD, so no divide/modulo logic is needed.
- Score advances by a configurable BCD step through a digit-serial adder: one digit per cycle.
- Increment requests that arrive while an add is in progress are queued in a small pending counter.
- Sits between game-event logic (collision/pass pulses) and the seven-segment/VGA score renderers.

---
 rtl/score_pkg.sv | 27 ++
 rtl/bcd_digit_add.sv | 26 ++
 rtl/bcd_score_keeper.sv | 191 +++++++++++++++++++
 tb/tb_bcd_score_keeper.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [1:0] EDGE_RISE = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CMP  = 2'd2
  } state_t;

  // Packed BCD value with the lowest 'digits' digits set to 9 (up to 8 digits).
  function automatic logic [31:0] BCD_NINES(input int digits);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        r = {r[27:0], 4'h9};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal carry; combinational.
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [4:0] raw_s;

  // Binary add, then fold back into 0..9 with a decimal carry.
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw_s > 5'd9) begin
      sum  = 4'(raw_s - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = raw_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// Packed-BCD score and session high score with a digit-serial adder.
// Optional macro SCORE_SAT_EN: saturate at all nines instead of wrapping.
module bcd_score_keeper
  import score_pkg::*;
#(
  parameter int                  DIGITS   = 4,
  parameter logic [4*DIGITS-1:0] STEP_BCD = 16'h0010,
  parameter int                  PEND_W   = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                plus,
  input  logic                round_clr,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic                busy,
  output logic                new_high,
  output logic                overflow,
  output logic                dropped
);

  localparam int W = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [W-1:0] NINES = W'(BCD_NINES(DIGITS));

  state_t            state_r, state_n;
  logic [1:0]        plus_f_r, rclr_f_r;
  logic [PEND_W-1:0] pend_r, pend_n;
  logic [IDX_W-1:0]  idx_r;
  logic              carry_r;
  logic [W-1:0]      work_r, score_r, high_r;
  logic              busy_r, new_high_r, overflow_r, dropped_r;

  logic              plus_ev_s, rclr_ev_s, start_s, dropped_s;
  logic [IDX_W+1:0]  shift_s;
  logic [BCD_W-1:0]  dig_a_s, dig_b_s, dig_sum_s;
  logic              dig_cout_s;
  logic [W-1:0]      work_n_s;

  assign plus_ev_s = (plus_f_r == EDGE_RISE);
  assign rclr_ev_s = (rclr_f_r == EDGE_RISE);

  // The one digit adder is steered to the digit selected by idx.
  assign shift_s  = {idx_r, 2'b00};
  assign dig_a_s  = BCD_W'(work_r >> shift_s);
  assign dig_b_s  = BCD_W'(STEP_BCD >> shift_s);
  assign work_n_s = (work_r & ~(W'(4'hF) << shift_s)) | (W'(dig_sum_s) << shift_s);

  bcd_digit_add u_digit_add (
    .a    (dig_a_s),
    .b    (dig_b_s),
    .cin  (carry_r),
    .sum  (dig_sum_s),
    .cout (dig_cout_s)
  );

  // Next state and pending-counter bookkeeping; round_clr overrides everything.
  always_comb begin
    state_n   = state_r;
    pend_n    = pend_r;
    start_s   = 1'b0;
    dropped_s = 1'b0;
    if (rclr_ev_s) begin
      state_n = IDLE;
      pend_n  = {PEND_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (plus_ev_s || (pend_r != {PEND_W{1'b0}})) begin
            state_n = ADD;
            start_s = 1'b1;
            // Starting from the queue while a new event queues nets to zero.
            if (!plus_ev_s) begin
              pend_n = pend_r - PEND_W'(1);
            end else begin
              pend_n = pend_r;
            end
          end else begin
            state_n = IDLE;
          end
        end
        ADD, CMP: begin
          if (state_r == CMP) begin
            state_n = IDLE;
          end else if (idx_r == LAST_IDX) begin
            state_n = CMP;
          end else begin
            state_n = ADD;
          end
          if (plus_ev_s && (pend_r == PEND_MAX)) begin
            dropped_s = 1'b1;
          end else if (plus_ev_s) begin
            pend_n = pend_r + PEND_W'(1);
          end else begin
            pend_n = pend_r;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register, input edge filters, pending counter and status flags.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r   <= IDLE;
      plus_f_r  <= 2'b00;
      rclr_f_r  <= 2'b00;
      pend_r    <= {PEND_W{1'b0}};
      busy_r    <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      plus_f_r  <= {plus_f_r[0], plus};
      rclr_f_r  <= {rclr_f_r[0], round_clr};
      pend_r    <= pend_n;
      busy_r    <= (state_n != IDLE);
      dropped_r <= dropped_s;
    end
  end

  // Digit-serial datapath, score commit and high-score compare.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx_r      <= {IDX_W{1'b0}};
      carry_r    <= 1'b0;
      work_r     <= {W{1'b0}};
      score_r    <= {W{1'b0}};
      high_r     <= {W{1'b0}};
      new_high_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      new_high_r <= 1'b0;
      overflow_r <= 1'b0;
      if (rclr_ev_s) begin
        score_r <= {W{1'b0}};
        idx_r   <= {IDX_W{1'b0}};
        carry_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_s) begin
              work_r  <= score_r;
              idx_r   <= {IDX_W{1'b0}};
              carry_r <= 1'b0;
            end else begin
              work_r  <= work_r;
            end
          end
          ADD: begin
            work_r  <= work_n_s;
            carry_r <= dig_cout_s;
            idx_r   <= idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
              overflow_r <= dig_cout_s;
`ifdef SCORE_SAT_EN
              score_r <= dig_cout_s ? NINES : work_n_s;
`else
              score_r <= work_n_s;
`endif
            end else begin
              score_r <= score_r;
            end
          end
          CMP: begin
            // Packed BCD orders the same as its binary reading.
            if (score_r > high_r) begin
              high_r     <= score_r;
              new_high_r <= 1'b1;
            end else begin
              high_r     <= high_r;
            end
          end
          default: begin
            idx_r <= {IDX_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign score_bcd = score_r;
  assign high_bcd  = high_r;
  assign busy      = busy_r;
  assign new_high  = new_high_r;
  assign overflow  = overflow_r;
  assign dropped   = dropped_r;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Self-checking bench for bcd_score_keeper (DIGITS=4, step decimal 10).
// Decimal-integer reference model; honours SCORE_SAT_EN when defined.
module tb_bcd_score_keeper;

  localparam int DIGITS = 4;
  localparam int STEP   = 10;
  localparam int MODV   = 10000;
  localparam int PMAX   = 3;
`ifdef SCORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        plus = 1'b0;
  logic        round_clr = 1'b0;
  logic [15:0] score_bcd, high_bcd;
  logic        busy, new_high, overflow, dropped;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state: decimal score/high, queued count, cycles into an increment
  int m_score = 0, m_high = 0, m_pend = 0, m_phase = 0;
  bit m_nh = 1'b0, m_ov = 1'b0, m_drop = 1'b0;
  bit p1 = 1'b0, p2 = 1'b0, r1 = 1'b0, r2 = 1'b0;
  int obs_nh = 0, obs_ov = 0, obs_drop = 0;

  bcd_score_keeper #(.DIGITS(4), .STEP_BCD(16'h0010), .PEND_W(2)) dut (
    .clk       (clk),
    .clr       (clr),
    .plus      (plus),
    .round_clr (round_clr),
    .score_bcd (score_bcd),
    .high_bcd  (high_bcd),
    .busy      (busy),
    .new_high  (new_high),
    .overflow  (overflow),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = 16'h0000;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r = r | (16'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  function automatic void model_step();
    bit ev_p, ev_r;
    int sum;
    ev_p = p1 && !p2;
    ev_r = r1 && !r2;
    m_nh = 1'b0; m_ov = 1'b0; m_drop = 1'b0;
    if (clr) begin
      m_score = 0; m_high = 0; m_pend = 0; m_phase = 0;
      p1 = 1'b0; p2 = 1'b0; r1 = 1'b0; r2 = 1'b0;
      return;
    end
    p2 = p1; p1 = plus; r2 = r1; r1 = round_clr;
    if (ev_r) begin
      m_score = 0; m_pend = 0; m_phase = 0;
    end else if (m_phase == 0) begin
      if (ev_p || m_pend > 0) begin
        if (!ev_p) m_pend--;
        m_phase = 1;
      end
    end else begin
      if (ev_p) begin
        if (m_pend == PMAX) m_drop = 1'b1;
        else m_pend++;
      end
      if (m_phase == DIGITS) begin
        sum = m_score + STEP;
        if (sum >= MODV) begin
          m_ov = 1'b1;
          m_score = SAT ? (MODV - 1) : (sum - MODV);
        end else begin
          m_score = sum;
        end
        m_phase++;
      end else if (m_phase == DIGITS + 1) begin
        if (m_score > m_high) begin
          m_high = m_score;
          m_nh = 1'b1;
        end
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("score", 32'(score_bcd), 32'(to_bcd(m_score)));
    check("high", 32'(high_bcd), 32'(to_bcd(m_high)));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("new_high", 32'(new_high), 32'(m_nh));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("dropped", 32'(dropped), 32'(m_drop));
    if (new_high) obs_nh++;
    if (overflow) obs_ov++;
    if (dropped) obs_drop++;
  endtask

  task automatic do_plus();
    plus = 1'b1; tick();
    plus = 1'b0; tick();
  endtask

  task automatic do_rclr();
    round_clr = 1'b1; tick();
    round_clr = 1'b0; tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !(m_phase == 0 && m_pend == 0); i++) tick();
    tick();
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1; tick();
    clr = 1'b0;
  endtask

  initial begin
    int nh0, ov0, dr0, guard;
    logic [15:0] exp_s, exp_h;

    // reset state
    do_clr();
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_high", 32'(high_bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // three isolated increments
    nh0 = obs_nh;
    repeat (3) begin do_plus(); wait_idle(); end
    check("p1_score", 32'(score_bcd), 32'h0030);
    check("p1_high", 32'(high_bcd), 32'h0030);
    check("p1_newhigh_cnt", 32'(obs_nh - nh0), 32'd3);

    // carry ripple 0090 -> 0100
    repeat (6) begin do_plus(); wait_idle(); end
    check("p2_pre", 32'(score_bcd), 32'h0090);
    ov0 = obs_ov;
    do_plus(); wait_idle();
    check("p2_score", 32'(score_bcd), 32'h0100);
    check("p2_no_ovf", 32'(obs_ov - ov0), 32'd0);

    // round clear keeps high
    do_clr();
    repeat (5) begin do_plus(); wait_idle(); end
    do_rclr();
    check("p5_score", 32'(score_bcd), 32'h0000);
    check("p5_high", 32'(high_bcd), 32'h0050);
    nh0 = obs_nh;
    repeat (2) begin do_plus(); wait_idle(); end
    check("p5_score2", 32'(score_bcd), 32'h0020);
    check("p5_no_newhigh", 32'(obs_nh - nh0), 32'd0);

    // back-to-back edges fill the queue; the sixth edge is dropped
    do_rclr();
    dr0 = obs_drop;
    repeat (6) do_plus();
    wait_idle();
    check("p3_score", 32'(score_bcd), 32'h0050);
    check("p3_drop_cnt", 32'(obs_drop - dr0), 32'd1);

    // round clear during the third digit with one queued increment
    plus = 1'b1; tick();
    plus = 1'b0; tick();
    plus = 1'b1; tick();
    plus = 1'b0; round_clr = 1'b1; tick();
    round_clr = 1'b0; tick();
    check("p6_score", 32'(score_bcd), 32'h0000);
    check("p6_busy", 32'(busy), 32'd0);
    repeat (8) tick();
    check("p6_still_idle", 32'(busy), 32'd0);
    do_clr();
    check("p6_high_clr", 32'(high_bcd), 32'h0000);

    // climb to 9990, then cross the top digit
    guard = 0;
    while (m_score != 9990 && guard < 1200) begin
      do_plus(); wait_idle(); guard++;
    end
    check("p4_pre", 32'(score_bcd), 32'h9990);
    ov0 = obs_ov;
    do_plus(); wait_idle();
    exp_s = SAT ? 16'h9999 : 16'h0000;
    exp_h = SAT ? 16'h9999 : 16'h9990;
    check("p4_score", 32'(score_bcd), 32'(exp_s));
    check("p4_high", 32'(high_bcd), 32'(exp_h));
    check("p4_ovf_cnt", 32'(obs_ov - ov0), 32'd1);
    do_plus(); wait_idle();
    exp_s = SAT ? 16'h9999 : 16'h0010;
    check("p4_score2", 32'(score_bcd), 32'(exp_s));
    check("p4_ovf_cnt2", 32'(obs_ov - ov0), SAT ? 32'd2 : 32'd1);

    // random traffic against the model
    do_clr();
    for (int i = 0; i < 600; i++) begin
      plus      = 1'($urandom_range(0, 1));
      round_clr = ($urandom_range(0, 23) == 0);
      clr       = ($urandom_range(0, 249) == 0);
      tick();
    end
    clr = 1'b0; plus = 1'b0; round_clr = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
